// File: rtl/apb4_slave_mem_ws.sv
// APB4 completer backed by a word-addressed memory with byte strobes.
// Each transfer can have a fixed or LFSR-driven number of wait states, and faults are reported on PSLVERR.
module apb4_slave_mem_ws #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 16,
  parameter int          MAX_WAIT   = 7,
  parameter int          WAIT_W     = 3,
  parameter int          PRIV_WORDS = 4,
  parameter logic [7:0]  RAND_SEED  = 8'hA5
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  input  logic [2:0]                PPROT,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [WAIT_W-1:0]         cfg_wait,
  input  logic                      cfg_rand
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int B      = $clog2(NBYTES);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << B) - 1);

  // The bus SETUP phase is decoded directly from PSEL/PENABLE. The edge that
  // closes it latches the request, so a zero-wait transfer takes two cycles.
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state;
  logic [WAIT_W-1:0]       cnt;
  logic [7:0]              lfsr;
  logic [IDX_W-1:0]        idx_q;
  logic                    write_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    setup_phase;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic [IDX_W-1:0]        idx_d;
  logic                    err_d;
  logic [WAIT_W-1:0]       wait_src;
  logic [WAIT_W-1:0]       wait_d;
  logic                    lfsr_fb;
  logic                    unused_prot;

  assign setup_phase = PSEL && !PENABLE;
  assign idx_full    = PADDR >> B;
  assign idx_d       = idx_full[IDX_W-1:0];
  assign err_d       = (|(PADDR & ALIGN_MASK))
                    || (idx_full >= ADDR_WIDTH'(DEPTH))
                    || (PWRITE && !PPROT[0] && (idx_full < ADDR_WIDTH'(PRIV_WORDS)));

  assign wait_src = cfg_rand ? lfsr[WAIT_W-1:0] : cfg_wait;
  assign wait_d   = (wait_src > WAIT_W'(MAX_WAIT)) ? WAIT_W'(MAX_WAIT) : wait_src;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1. The polynomial is maximal-length, so the register never reaches zero.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign PREADY      = (state == ACCESS) && (cnt == '0);
  assign PSLVERR     = PREADY && err_q;
  assign unused_prot = ^PPROT[2:1];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      lfsr    <= RAND_SEED;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      PRDATA  <= '0;
      // NOTE: the memory is cleared by reset here, so it is built as flops and not as a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (setup_phase) begin
            idx_q   <= idx_d;
            write_q <= PWRITE;
            err_q   <= err_d;
            cnt     <= wait_d;
            state   <= ACCESS;
            if (!PWRITE) PRDATA <= err_d ? '0 : mem[idx_d];
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            if (cnt != '0) begin
              cnt <= cnt - WAIT_W'(1);
            end else begin
              if (write_q && !err_q) begin
                for (int i = 0; i < NBYTES; i++)
                  if (PSTRB[i]) mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
              end
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_slave_mem_ws.sv
// Randomised and directed testbench for apb4_slave_mem_ws.
// The driver pushes the expected responses into a queue, and a monitor process pops and compares them at each completion.
module tb_apb4_slave_mem_ws;

  localparam int MAX_WAIT = 7;
  localparam int DEPTH    = 16;
  localparam int PRIV     = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [2:0]  PPROT = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [2:0]  cfg_wait = '0;
  logic        cfg_rand = 1'b0;

  apb4_slave_mem_ws dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .cfg_wait(cfg_wait), .cfg_rand(cfg_rand)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;   // -1: random wait count, recorded instead of compared
  } exp_t;

  exp_t        exp_q[$];
  int          rand_waits[$];
  int          run1[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] hold_m = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    hold_m = '0;
    exp_q.delete();
  endtask

  // Reference behaviour built directly from the address, protection and strobe rules.
  task automatic model(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [2:0] prot, output exp_t e);
    int  idx;
    bit  err;
    idx = int'(addr) / 4;
    err = (addr % 4 != 0) || (idx >= DEPTH) || (wr && !prot[0] && idx < PRIV);
    if (!wr) hold_m = err ? 32'h0 : mem_m[idx];
    else if (!err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
    e.rdata = hold_m;
    e.err   = err;
    e.waits = cfg_rand ? -1 : ((int'(cfg_wait) > MAX_WAIT) ? MAX_WAIT : int'(cfg_wait));
  endtask

  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot, input bit bump);
    exp_t e;
    bit   done;
    @(posedge PCLK); #1;
    model(wr, addr, data, strb, prot, e);
    exp_q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = data; PSTRB = strb; PPROT = prot;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (bump) cfg_wait = 3'd7;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (PREADY) done = 1'b1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_timeout: addr %h got no PREADY within 40 cycles required completion", addr);
    end
  endtask

  task automatic idle(input int n);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (n - 1) @(posedge PCLK);
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    model_clear();
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
  endtask

  // Set up a write, spend n ACCESS cycles in it, then either drop PSEL or assert reset.
  task automatic broken_write(input logic [11:0] addr, input logic [31:0] data, input int n, input bit rst);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr;
    PWDATA = data; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (n) @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    if (rst) begin
      PRESET = 1'b1;
      model_clear();
    end
  endtask

  task automatic rand_run();
    rand_waits.delete();
    do_reset();
    cfg_rand = 1'b1;
    for (int i = 0; i < 200; i++) xfer(1'b0, 12'((i % DEPTH) * 4), 32'h0, 4'h0, 3'b000, 1'b0);
    idle(2);
    cfg_rand = 1'b0;
  endtask

  // Monitor: pops one expectation per completed transfer.
  always @(negedge PCLK) begin
    if (PRESET) begin
      wait_cnt = 0;
    end else if (PSEL && !PENABLE) begin
      wait_cnt = 0;
    end else if (PSEL && PENABLE && !PREADY) begin
      wait_cnt++;
    end else if (PSEL && PENABLE && PREADY) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_completion: addr %h completed with no expectation queued", PADDR);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("prdata", PRDATA, e.rdata);
        check("pslverr", {31'b0, PSLVERR}, {31'b0, e.err});
        if (e.waits >= 0) check("wait_states", wait_cnt, e.waits);
        else rand_waits.push_back(wait_cnt);
      end
      wait_cnt = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] a;
    bit          seen [8];
    int          distinct, maxw, diffs;

    model_clear();
    repeat (2) @(negedge PCLK);
    check("reset_prdata", PRDATA, 32'h0);
    check("reset_pready", {31'b0, PREADY}, 32'h0);
    check("reset_pslverr", {31'b0, PSLVERR}, 32'h0);
    @(posedge PCLK); #1 PRESET = 1'b0;

    // Basic zero-wait write and readback.
    cfg_wait = 3'd0;
    xfer(1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 3'b001, 1'b0);
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 1'b0);
    idle(1);

    // Fixed waits; a change to cfg_wait in the middle of the transfer is ignored.
    cfg_wait = 3'd3;
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 1'b0);
    cfg_wait = 3'd3;
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 1'b1);
    cfg_wait = 3'd0;
    idle(1);

    // Byte strobes.
    xfer(1'b1, 12'h00C, 32'h11223344, 4'b0101, 3'b001, 1'b0);
    xfer(1'b0, 12'h00C, 32'h0, 4'h0, 3'b001, 1'b0);
    check("strobe_model", mem_m[3], 32'h00220044);
    xfer(1'b1, 12'h00C, 32'hFFFFFFFF, 4'b0000, 3'b001, 1'b0);
    xfer(1'b0, 12'h00C, 32'h0, 4'h0, 3'b001, 1'b0);

    // Misaligned, out-of-range and privilege faults.
    xfer(1'b1, 12'h00A, 32'h55555555, 4'hF, 3'b001, 1'b0);
    xfer(1'b1, 12'h040, 32'h66666666, 4'hF, 3'b001, 1'b0);
    xfer(1'b1, 12'h004, 32'h77777777, 4'hF, 3'b000, 1'b0);
    xfer(1'b0, 12'h00A, 32'h0, 4'h0, 3'b001, 1'b0);
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 1'b0);
    xfer(1'b0, 12'h004, 32'h0, 4'h0, 3'b001, 1'b0);
    xfer(1'b1, 12'h004, 32'h77777777, 4'hF, 3'b001, 1'b0);
    xfer(1'b0, 12'h004, 32'h0, 4'h0, 3'b000, 1'b0);
    idle(1);

    // Abort by dropping PSEL during a 5-wait write.
    xfer(1'b1, 12'h014, 32'hCAFEF00D, 4'hF, 3'b001, 1'b0);
    cfg_wait = 3'd5;
    broken_write(12'h014, 32'h12345678, 2, 1'b0);
    @(negedge PCLK);
    check("abort_pready", {31'b0, PREADY}, 32'h0);
    cfg_wait = 3'd0;
    xfer(1'b0, 12'h014, 32'h0, 4'h0, 3'b001, 1'b0);
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 1'b0);

    // Reset in the middle of a later write.
    cfg_wait = 3'd5;
    broken_write(12'h018, 32'h87654321, 2, 1'b1);
    @(negedge PCLK);
    check("midrst_prdata", PRDATA, 32'h0);
    check("midrst_pready", {31'b0, PREADY}, 32'h0);
    check("midrst_pslverr", {31'b0, PSLVERR}, 32'h0);
    @(posedge PCLK); #1 PRESET = 1'b0;
    cfg_wait = 3'd0;
    xfer(1'b0, 12'h018, 32'h0, 4'h0, 3'b001, 1'b0);
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b001, 1'b0);
    xfer(1'b1, 12'h018, 32'hA5A5A5A5, 4'hF, 3'b001, 1'b0);
    xfer(1'b0, 12'h018, 32'h0, 4'h0, 3'b001, 1'b0);
    idle(1);

    // PENABLE=1 seen in IDLE without a SETUP phase is ignored.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h018;
    repeat (2) begin
      @(negedge PCLK);
      check("idle_penable_pready", {31'b0, PREADY}, 32'h0);
    end
    idle(1);

    // Random mixed traffic with random fixed wait counts.
    for (int i = 0; i < 40; i++) begin
      a = 12'($urandom_range(0, 'h4F));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      cfg_wait = 3'($urandom_range(0, 7));
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 1'b0);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(1);
    cfg_wait = 3'd0;

    // Pseudo-random wait counts: bounded, varied, and reproducible from reset.
    rand_run();
    run1 = rand_waits;
    rand_run();
    check("rand_count1", run1.size(), 200);
    check("rand_count2", rand_waits.size(), 200);
    distinct = 0; maxw = 0; diffs = 0;
    foreach (rand_waits[i]) begin
      if (rand_waits[i] > maxw) maxw = rand_waits[i];
      if (rand_waits[i] >= 0 && rand_waits[i] < 8) seen[rand_waits[i]] = 1'b1;
      if (i < run1.size() && run1[i] != rand_waits[i]) diffs++;
    end
    foreach (seen[i]) if (seen[i]) distinct++;
    check("rand_max_le_max_wait", {31'b0, maxw <= MAX_WAIT}, 32'h1);
    check("rand_distinct_ge_4", {31'b0, distinct >= 4}, 32'h1);
    check("rand_repeatable", diffs, 0);

    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb4_slave_mem_ws.md
Name: apb4_slave_mem_ws

Overview:
- Parametrised APB4 completer: word-addressed memory with byte strobes, programmable or pseudo-random wait states, and PSLVERR on range, alignment and privilege faults.
- Serves as the configurable reference DUT driven by the APB4 slave VIP test environment.
- Generalises the fixed single-configuration slave in data width, depth, wait-state mode and error checking.

Parameters:
ADDR_WIDTH, 12, PADDR width in bits
DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32
DEPTH, 16, number of memory words
MAX_WAIT, 7, upper bound on inserted wait states
WAIT_W, 3, width of cfg_wait; must satisfy 2^WAIT_W > MAX_WAIT
PRIV_WORDS, 4, words 0..PRIV_WORDS-1 are write-protected against unprivileged access
RAND_SEED, 8'hA5, LFSR reset value; must be non-zero

Ports:
PCLK  in  1  clock, rising edge
PRESET  in  1  asynchronous reset, active-high
PSEL  in  1  completer select
PENABLE  in  1  access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  write byte lanes
PPROT  in  3  protection; bit 0 = privileged
PRDATA  out  DATA_WIDTH  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error; valid only while PREADY=1
cfg_wait  in  WAIT_W  fixed wait-state count, sampled in SETUP
cfg_rand  in  1  1 = pseudo-random wait count, sampled in SETUP

Behaviour:
- Reset: one clock, PCLK; reset is asynchronous and active-high (PRESET). On assertion:
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - state=IDLE, wait counter=0, LFSR=RAND_SEED.
  - All memory words cleared to 0.
  - Reset mid-transfer aborts the transfer; no write commits.
- Address decode: B = log2(DATA_WIDTH/8). idx = PADDR[ADDR_WIDTH-1:B].
- Error (err) when any of:
  - PADDR[B-1:0] != 0 (misaligned);
  - idx >= DEPTH;
  - PWRITE=1 and PPROT[0]=0 and idx < PRIV_WORDS.
- States:
  - IDLE → SETUP when PSEL=1 and PENABLE=0.
  - In IDLE, PSEL=1 with PENABLE=1 is ignored: PREADY stays 0 and state stays IDLE.
  - SETUP edge latches addr, write, err and the wait count. Count = cfg_wait clipped to MAX_WAIT, or, if cfg_rand=1, lfsr[WAIT_W-1:0] clipped to MAX_WAIT.
  - Read with err=0: PRDATA <= mem[idx] at the SETUP edge. Read with err=1: PRDATA <= 0.
  - SETUP → ACCESS unconditionally.
  - ACCESS: PREADY = (cnt==0), combinational from registered state.
  - ACCESS with cnt!=0: cnt decrements each cycle while PSEL=1 and PENABLE=1.
  - ACCESS with PSEL=0: abort; → IDLE; no write; PREADY=0.
- Completion edge (ACCESS, PSEL=1, PENABLE=1, PREADY=1):
  - Write with err=0: each lane with PSTRB[i]=1 updates mem[idx][8i+7:8i]; other lanes hold.
  - Write with err=1: memory unchanged.
  - Next state is SETUP if PSEL=1 and PENABLE=0 on the following cycle (back-to-back), otherwise IDLE.
- PSLVERR = err while PREADY=1, else 0.
- PRDATA holds its value after completion until the next read SETUP. Writes do not alter PRDATA.
- PSTRB is ignored on reads.
- Latency: zero wait gives a 2-cycle transfer (SETUP + 1 ACCESS). N waits gives N+2 cycles.
- cfg_wait and cfg_rand changes during ACCESS have no effect on the current transfer.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every cycle outside reset. Never reaches 0.

Test Plan:
- Reset, then cfg_wait=0: write 32'hDEADBEEF to 0x008 with PSTRB=4'hF, PPROT=3'b001; read 0x008 → PRDATA=32'hDEADBEEF, PREADY high in first ACCESS cycle, PSLVERR=0, 2-cycle transfers.
- cfg_wait=3: read 0x008 → PREADY low for exactly 3 ACCESS cycles, high on the 4th; total 5 cycles. Raising cfg_wait to 7 mid-ACCESS does not lengthen the transfer.
- Write 32'h11223344 to 0x00C with PSTRB=4'b0101 over prior 0 → readback 32'h00220044. Write to 0x00C with PSTRB=0 → unchanged.
- Errors each give PSLVERR=1 with PREADY and leave memory unchanged:
  - misaligned 0x00A;
  - out-of-range 0x040 (DEPTH=16);
  - write to 0x004 with PPROT=3'b000.
  Same write with PPROT=3'b001 → PSLVERR=0 and commits.
- cfg_rand=1, 200 back-to-back reads:
  - every wait count ≤ MAX_WAIT;
  - at least 4 distinct counts;
  - sequence identical across two runs with RAND_SEED=8'hA5.
- Drop PSEL during a 5-wait write, then assert PRESET mid-ACCESS of a later write → target words keep their old value (0 after reset), all outputs 0, next transfer completes normally.
